frame_buffer_swap_ctrl: RTL and testbench

//  Double-buffered 12-bit framebuffer directly downstream of the drawing manager. Absorbs its pixel writes

---
 rtl/frame_buffer_swap_ctrl.sv | 164 ++++++++++++++++
 tb/tb_frame_buffer_swap_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_swap_ctrl.sv
// Double-buffered RGB444 framebuffer: absorbs drawing writes into the back buffer, scans out the front buffer,
// and swaps the two only at vertical blank after frame_done. Optional macro: FB_PERF_COUNTERS_EN.
module frame_buffer_swap_ctrl #(
    parameter int BUFFER_WIDTH      = 160,
    parameter int BUFFER_HEIGHT     = 120,
    parameter int BUFFER_DATA_WIDTH = 12,
    parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         wr_en,
    input  logic [BUFFER_ADDR_WIDTH-1:0] wr_addr,
    input  logic [BUFFER_DATA_WIDTH-1:0] wr_data,
    input  logic                         frame_done,
    input  logic                         vblank_start,
    input  logic [BUFFER_ADDR_WIDTH-1:0] rd_addr,
    output logic [BUFFER_DATA_WIDTH-1:0] rd_data,
    output logic                         draw_start,
    output logic                         draw_ack,
    output logic                         back_sel,
    output logic                         wr_dropped,
    output logic [15:0]                  swap_count,
    output logic [15:0]                  late_count,
    output logic [1:0]                   state_dbg
);

    localparam int DEPTH = BUFFER_WIDTH * BUFFER_HEIGHT;
    localparam logic [BUFFER_ADDR_WIDTH:0] DEPTH_L = (BUFFER_ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        ST_INIT        = 2'd0,
        ST_DRAWING     = 2'd1,
        ST_WAIT_VBLANK = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic front;
    logic wr_accept;
    logic wr_reject;
    logic wr_in_range;
    logic rd_in_range;

    logic [BUFFER_DATA_WIDTH-1:0] mem0 [DEPTH];
    logic [BUFFER_DATA_WIDTH-1:0] mem1 [DEPTH];
    logic [BUFFER_DATA_WIDTH-1:0] rd_raw0;
    logic [BUFFER_DATA_WIDTH-1:0] rd_raw1;
    logic                         rd_valid_q;
    logic                         rd_front_q;

    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
    assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);

    // Handshake to the drawing manager: draw_start and draw_ack are single-cycle
    // pulses with no ready/backpressure; frame_done and vblank_start are sampled
    // as single-cycle pulses and never held.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        draw_start = 1'b0;
        draw_ack   = 1'b0;
        wr_accept  = 1'b0;
        wr_reject  = wr_en;
        case (state_q)
            ST_INIT: begin
                // Gated by rstn so the pulse stays low while reset is held.
                state_d    = ST_DRAWING;
                draw_start = rstn;
            end
            ST_DRAWING: begin
                wr_accept = wr_en && wr_in_range;
                wr_reject = wr_en && !wr_in_range;
                // A vblank coinciding with frame_done is skipped to avoid tearing.
                if (frame_done) begin
                    state_d = ST_WAIT_VBLANK;
                end
            end
            ST_WAIT_VBLANK: begin
                if (vblank_start) begin
                    state_d  = ST_DRAWING;
                    draw_ack = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign state_dbg = state_q;
    assign back_sel  = ~front;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            front      <= 1'b0;
            wr_dropped <= 1'b0;
        end else begin
            if (draw_ack) begin
                front <= ~front;
            end
            if (wr_reject) begin
                wr_dropped <= 1'b1;
            end
        end
    end

    // Storage kept free of reset so each array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_accept && front) begin
            mem0[wr_addr] <= wr_data;
        end
        rd_raw0 <= mem0[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (wr_accept && !front) begin
            mem1[wr_addr] <= wr_data;
        end
        rd_raw1 <= mem1[rd_addr];
    end

    // Front is captured alongside the RAM read, so a swap-cycle read still sees the old front.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_front_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_in_range;
            rd_front_q <= front;
        end
    end

    assign rd_data = rd_valid_q ? (rd_front_q ? rd_raw1 : rd_raw0) : '0;

`ifdef FB_PERF_COUNTERS_EN
    logic late_evt;
    assign late_evt = (state_q == ST_DRAWING) && vblank_start && !frame_done;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            swap_count <= 16'h0;
            late_count <= 16'h0;
        end else begin
            if (draw_ack) begin
                swap_count <= swap_count + 16'h1;
            end
            if (late_evt) begin
                late_count <= late_count + 16'h1;
            end
        end
    end
`else
    assign swap_count = 16'h0;
    assign late_count = 16'h0;
`endif

endmodule

// File: tb/tb_frame_buffer_swap_ctrl.sv
// Bench for frame_buffer_swap_ctrl: directed steps then random traffic, each cycle compared
// against a phase/queue model of the double-buffer swap rules.
module tb_frame_buffer_swap_ctrl;
    localparam int W     = 160;
    localparam int H     = 120;
    localparam int DEPTH = W * H;
    localparam int AW    = 15;
    localparam int DW    = 12;

    logic          clk = 1'b0;
    logic          rstn;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          frame_done;
    logic          vblank_start;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          draw_start;
    logic          draw_ack;
    logic          back_sel;
    logic          wr_dropped;
    logic [15:0]   swap_count;
    logic [15:0]   late_count;
    logic [1:0]    state_dbg;

    always #5 clk = ~clk;

    frame_buffer_swap_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_done   (frame_done),
        .vblank_start (vblank_start),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .draw_start   (draw_start),
        .draw_ack     (draw_ack),
        .back_sel     (back_sel),
        .wr_dropped   (wr_dropped),
        .swap_count   (swap_count),
        .late_count   (late_count),
        .state_dbg    (state_dbg)
    );

    int checks = 0;
    int errors = 0;

    // Model: pixel store keyed by buffer*DEPTH+addr, plus frame phase flags.
    logic [DW-1:0] ref_mem [int];
    logic [12:0]   exp_q[$];
    bit            m_started;
    bit            m_wait;
    bit            m_front;
    bit            m_dropped;
    int            m_swaps;
    int            m_late;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int exp_swaps();
`ifdef FB_PERF_COUNTERS_EN
        return m_swaps;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_late();
`ifdef FB_PERF_COUNTERS_EN
        return m_late;
`else
        return 0;
`endif
    endfunction

    task automatic do_reset();
        rstn         = 1'b0;
        wr_en        = 1'b0;
        wr_addr      = '0;
        wr_data      = '0;
        frame_done   = 1'b0;
        vblank_start = 1'b1;
        rd_addr      = '0;
        m_started = 0; m_wait = 0; m_front = 0; m_dropped = 0; m_swaps = 0; m_late = 0;
        #1;
        chk("rst_draw_start", 32'(draw_start), 0);
        chk("rst_draw_ack", 32'(draw_ack), 0);
        chk("rst_back_sel", 32'(back_sel), 1);
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_wr_dropped", 32'(wr_dropped), 0);
        chk("rst_swap_count", 32'(swap_count), 0);
        chk("rst_late_count", 32'(late_count), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_draw_start", 32'(draw_start), 0);
        vblank_start = 1'b0;
        rstn = 1'b1;
        exp_q.delete();
        exp_q.push_back(13'h1000);
    endtask

    task automatic cycle(input bit we, input int wa, input int wd, input bit fd, input bit vb, input int ra);
        logic [12:0] rd_exp;
        int key;
        wr_en        = we;
        wr_addr      = wa[AW-1:0];
        wr_data      = wd[DW-1:0];
        frame_done   = fd;
        vblank_start = vb;
        rd_addr      = ra[AW-1:0];
        @(negedge clk);
        chk("draw_start", 32'(draw_start), 32'(!m_started));
        chk("draw_ack", 32'(draw_ack), 32'(m_started && m_wait && vb));
        chk("back_sel", 32'(back_sel), 32'(!m_front));
        chk("wr_dropped", 32'(wr_dropped), 32'(m_dropped));
        chk("swap_count", 32'(swap_count), 32'(exp_swaps()));
        chk("late_count", 32'(late_count), 32'(exp_late()));
        chk("state_known", 32'(^state_dbg !== 1'bx), 1);
        rd_exp = exp_q.pop_front();
        if (rd_exp[12]) chk("rd_data", 32'(rd_data), 32'(rd_exp[DW-1:0]));
        // Effects of the coming clock edge.
        if (ra >= DEPTH) begin
            exp_q.push_back(13'h1000);
        end else begin
            key = int'(m_front) * DEPTH + ra;
            if (ref_mem.exists(key)) exp_q.push_back({1'b1, ref_mem[key]});
            else exp_q.push_back(13'h0000);
        end
        if (we) begin
            if (wa < DEPTH && m_started && !m_wait) ref_mem[int'(!m_front) * DEPTH + wa] = wd[DW-1:0];
            else m_dropped = 1;
        end
        if (!m_started) begin
            m_started = 1;
        end else if (!m_wait) begin
            if (fd) m_wait = 1;
            else if (vb) m_late = (m_late + 1) & 16'hFFFF;
        end else if (vb) begin
            m_front = !m_front;
            m_wait  = 0;
            m_swaps = (m_swaps + 1) & 16'hFFFF;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rstn = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        // Start pulse appears only in the first cycle after release.
        idle(3);

        // Basic frame: write, finish, swap at a later vblank, read back from the new front.
        cycle(1, 5, 'hABC, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(9);
        cycle(0, 0, 0, 0, 1, 5);
        cycle(0, 0, 0, 0, 0, 5);
        cycle(0, 0, 0, 0, 0, 5);
        chk("abc_readback", 32'(rd_data), 32'h0ABC);
        chk("swap_once", 32'(back_sel), 0);

        // frame_done and vblank together: that vblank is skipped.
        cycle(1, 9, 'h123, 0, 0, 9);
        cycle(0, 0, 0, 1, 1, 9);
        idle(3);
        cycle(0, 0, 0, 0, 1, 9);
        idle(2);

        // Out-of-range write, then a write while waiting for vblank.
        cycle(1, DEPTH, 'h555, 0, 0, DEPTH);
        cycle(0, 0, 0, 1, 0, 32767);
        cycle(1, 7, 'h777, 0, 0, 7);
        cycle(0, 0, 0, 0, 1, 7);
        idle(2);

        // Late vblanks while still drawing.
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 0, 0, 1, 0);
            cycle(0, 0, 0, 0, 0, 0);
        end

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            int wa;
            int ra;
            wa = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 32767)) : int'($urandom_range(0, 63));
            ra = ($urandom_range(0, 15) == 0) ? int'($urandom_range(DEPTH, 32767)) : int'($urandom_range(0, 63));
            cycle(1'($urandom_range(0, 1)), wa, int'($urandom_range(0, 4095)),
                  ($urandom_range(0, 19) == 0), ($urandom_range(0, 14) == 0), ra);
        end

        // Reset while waiting for vblank.
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0, 0);
        idle(2);
        do_reset();
        idle(4);
        cycle(1, 11, 'h9F3, 1, 0, 11);
        cycle(0, 0, 0, 0, 1, 11);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
